// File: rtl/pwm_dt_pkg.sv
// pwm_dt_pkg: shared state encoding and default sizing for the dead-time generator
package pwm_dt_pkg;
    localparam int DT_W_DEF       = 4;
    localparam int DEFAULT_DT_DEF = 2;
    localparam int DROP_W_DEF     = 8;

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        LS_ON    = 3'd1,
        DT_TO_HS = 3'd2,
        HS_ON    = 3'd3,
        DT_TO_LS = 3'd4,
        FAULT    = 3'd5
    } state_t;
endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// pwm_deadtime_gen_if: control inputs and gate-drive outputs of one half-bridge leg
interface pwm_deadtime_gen_if #(
    parameter int DT_W   = 4,
    parameter int DROP_W = 8
);
    logic              pwm_in;
    logic [DT_W-1:0]   dt_cfg;
    logic              dt_load;
    logic              fault_in;
    logic              fault_clr;
    logic              hs_out;
    logic              ls_out;
    logic              fault_latched;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output pwm_in, dt_cfg, dt_load, fault_in, fault_clr,
        input  hs_out, ls_out, fault_latched, drop_cnt
    );

    modport slave (
        input  pwm_in, dt_cfg, dt_load, fault_in, fault_clr,
        output hs_out, ls_out, fault_latched, drop_cnt
    );
endinterface

// File: rtl/pwm_dt_timer.sv
// pwm_dt_timer: loadable down-counter that stops at zero
module pwm_dt_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);
    assign zero = cnt == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && !zero) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary gate drive with dead time, pulse swallowing and fault latch
module pwm_deadtime_gen
    import pwm_dt_pkg::*;
#(
    parameter int DT_W       = DT_W_DEF,
    parameter int DEFAULT_DT = DEFAULT_DT_DEF,
    parameter int DROP_W     = DROP_W_DEF
) (
    input logic clk,
    input logic rst,
    pwm_deadtime_gen_if.slave bus
);
    state_t            state, nxt;
    logic              pwm_q, load, drop, cnt_zero, dec;
    logic [DT_W-1:0]   dt_reg, dt_eff, cnt;
    logic              hs_q, ls_q, fl_q;
    logic [DROP_W-1:0] drop_q;

    // a zero setting still gives one both-low cycle
    assign dt_eff = (dt_reg == '0) ? DT_W'(1) : dt_reg;
    assign dec    = (state == DT_TO_HS) || (state == DT_TO_LS);

    pwm_dt_timer #(.W(DT_W)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(load),
        .dec(dec),
        .load_val(dt_eff - 1'b1),
        .cnt(cnt),
        .zero(cnt_zero)
    );

    always_comb begin
        nxt  = state;
        load = 1'b0;
        drop = 1'b0;
        case (state)
            OFF: begin
                nxt  = pwm_q ? DT_TO_HS : DT_TO_LS;
                load = 1'b1;
            end
            LS_ON: if (pwm_q) begin
                nxt  = DT_TO_HS;
                load = 1'b1;
            end
            HS_ON: if (!pwm_q) begin
                nxt  = DT_TO_LS;
                load = 1'b1;
            end
            // returning to the side that was on means the pulse was swallowed
            DT_TO_HS, DT_TO_LS: if (cnt_zero) begin
                nxt  = pwm_q ? HS_ON : LS_ON;
                drop = pwm_q ^ (state == DT_TO_HS);
            end
            FAULT: if (bus.fault_clr && !bus.fault_in) nxt = OFF;
            default: nxt = OFF;
        endcase
        if (bus.fault_in) begin
            nxt  = FAULT;
            load = 1'b0;
            drop = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= OFF;
            pwm_q  <= 1'b0;
            dt_reg <= DT_W'(DEFAULT_DT);
            hs_q   <= 1'b0;
            ls_q   <= 1'b0;
            fl_q   <= 1'b0;
            drop_q <= '0;
        end else begin
            state  <= nxt;
            pwm_q  <= bus.pwm_in;
            hs_q   <= nxt == HS_ON;
            ls_q   <= nxt == LS_ON;
            fl_q   <= nxt == FAULT;
            if (bus.dt_load) dt_reg <= bus.dt_cfg;
            if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    assign bus.hs_out        = hs_q;
    assign bus.ls_out        = ls_q;
    assign bus.fault_latched = fl_q;
    assign bus.drop_cnt      = drop_q;
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb_pwm_deadtime_gen: table-driven vectors plus directed sequences for reset, zero dead time and saturation
module tb_pwm_deadtime_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pwm_deadtime_gen_if #(.DT_W(4), .DROP_W(8)) b ();

    pwm_deadtime_gen #(.DT_W(4), .DEFAULT_DT(2), .DROP_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    typedef struct {
        logic       pwm;
        logic       flt;
        logic       clr;
        logic       ld;
        logic [3:0] cfg;
        logic       hs;
        logic       ls;
        logic       fl;
        int         drop;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input int n, input logic pwm, flt, clr, ld, input logic [3:0] cfg,
                     input logic hs, ls, fl, input int drop);
        vec_t e;
        e = '{pwm, flt, clr, ld, cfg, hs, ls, fl, drop};
        repeat (n) tbl.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({b.hs_out, b.ls_out, b.fault_latched, b.drop_cnt});
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int   k, ov, wraps, prev;
        vec_t e;
        b.pwm_in = 1'b0; b.dt_cfg = 4'd0; b.dt_load = 1'b0; b.fault_in = 1'b0; b.fault_clr = 1'b0;
        //   n pwm flt clr ld cfg  hs ls fl drop
        v(2, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0,   0, 1, 0, 0);
        v(1, 1, 0, 0, 0, 0,   0, 1, 0, 0);
        v(2, 1, 0, 0, 0, 0,   0, 0, 0, 0);
        v(4, 1, 0, 0, 0, 0,   1, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
        v(2, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0,   0, 1, 0, 0);
        v(1, 1, 0, 0, 0, 0,   0, 1, 0, 0);
        v(2, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0,   0, 1, 0, 1);
        v(1, 1, 0, 0, 0, 0,   0, 1, 0, 1);
        v(2, 1, 0, 0, 0, 0,   0, 0, 0, 1);
        v(1, 1, 0, 0, 0, 0,   1, 0, 0, 1);
        v(1, 1, 1, 0, 0, 0,   0, 0, 1, 1);
        v(1, 1, 1, 1, 0, 0,   0, 0, 1, 1);
        v(1, 1, 0, 0, 0, 0,   0, 0, 1, 1);
        v(1, 1, 0, 1, 0, 0,   0, 0, 0, 1);
        v(2, 1, 0, 0, 0, 0,   0, 0, 0, 1);
        v(1, 1, 0, 0, 0, 0,   1, 0, 0, 1);
        v(1, 1, 0, 0, 1, 5,   1, 0, 0, 1);
        v(1, 0, 0, 0, 0, 0,   1, 0, 0, 1);
        v(5, 0, 0, 0, 0, 0,   0, 0, 0, 1);
        v(1, 0, 0, 0, 0, 0,   0, 1, 0, 1);
        v(1, 1, 0, 0, 0, 0,   0, 1, 0, 1);
        v(2, 1, 0, 0, 0, 0,   0, 0, 0, 1);
        v(3, 0, 0, 0, 0, 0,   0, 0, 0, 1);
        v(1, 0, 0, 0, 0, 0,   0, 1, 0, 2);
        v(1, 1, 0, 0, 0, 0,   0, 1, 0, 2);
        v(5, 1, 0, 0, 0, 0,   0, 0, 0, 2);
        v(2, 1, 0, 0, 0, 0,   1, 0, 0, 2);
        v(1, 0, 0, 0, 0, 0,   1, 0, 0, 2);
        v(5, 0, 0, 0, 0, 0,   0, 0, 0, 2);
        v(1, 0, 0, 0, 0, 0,   0, 1, 0, 2);

        step();
        step();
        chk("reset_state", outs(), 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            e = tbl[i];
            b.pwm_in = e.pwm; b.fault_in = e.flt; b.fault_clr = e.clr; b.dt_load = e.ld; b.dt_cfg = e.cfg;
            step();
            if (outs() !== int'({e.hs, e.ls, e.fl, 8'(e.drop)})) begin
                n_err++;
                $display("FAIL vec%0d: got %0h expected %0h", i + 1, outs(), int'({e.hs, e.ls, e.fl, 8'(e.drop)}));
            end
            n_vec++;
        end
        b.dt_load = 1'b0; b.fault_in = 1'b0; b.fault_clr = 1'b0;

        // async reset while HS_ON
        b.pwm_in = 1'b1;
        k = 0;
        while (!b.hs_out && k < 20) begin step(); k++; end
        chk("reach_hs", int'(b.hs_out), 1);
        #2 rst = 1'b1;
        #1 chk("async_rst", outs(), 0);
        step();
        rst = 1'b0;
        b.pwm_in = 1'b0;
        step();
        step();
        chk("rel_ls_early", outs(), 0);
        step();
        chk("rel_ls_on", outs(), int'({3'b010, 8'd0}));

        // zero dead time still yields one both-low cycle
        b.dt_cfg = 4'd0; b.dt_load = 1'b1;
        step();
        b.dt_load = 1'b0; b.pwm_in = 1'b1;
        step();
        chk("dt0_e0", int'({b.hs_out, b.ls_out}), 1);
        step();
        chk("dt0_gap_r", int'({b.hs_out, b.ls_out}), 0);
        step();
        chk("dt0_hs", int'({b.hs_out, b.ls_out}), 2);
        b.pwm_in = 1'b0;
        step();
        step();
        chk("dt0_gap_f", int'({b.hs_out, b.ls_out}), 0);
        step();
        chk("dt0_ls", int'({b.hs_out, b.ls_out}), 1);

        ov = 0;
        for (int i = 0; i < 1000; i++) begin
            b.pwm_in = 1'($urandom_range(0, 1));
            step();
            if (b.hs_out && b.ls_out) ov++;
        end
        chk("overlap_cnt", ov, 0);

        // saturating drop counter with 1-cycle pulses at D=2
        b.dt_cfg = 4'd2; b.dt_load = 1'b1; b.pwm_in = 1'b0;
        step();
        b.dt_load = 1'b0;
        repeat (6) step();
        wraps = 0;
        prev = int'(b.drop_cnt);
        for (int i = 0; i < 300; i++) begin
            b.pwm_in = 1'b1;
            step();
            b.pwm_in = 1'b0;
            repeat (5) step();
            if (int'(b.drop_cnt) < prev) wraps++;
            prev = int'(b.drop_cnt);
        end
        chk("drop_wrap", wraps, 0);
        chk("drop_sat", int'(b.drop_cnt), 255);
        chk("ls_after_sat", int'({b.hs_out, b.ls_out, b.fault_latched}), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
- Downstream stage of the PWM generator. Turns its single-ended PWM into a complementary high-side/low-side gate-drive pair for a half-bridge.
- Inserts a programmable dead time (both outputs low) at every transition. Swallows pulses shorter than the dead time.
- Latches an external fault, forcing both outputs low until software clears it.
- Sits between the PWM compare output and the uo_out pins.

Parameters:
- DT_W, 4, width of dead-time config/counter in clk cycles
- DEFAULT_DT, 2, dead time loaded into dt_reg at reset
- DROP_W, 8, width of the saturating swallowed-pulse counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pwm_in  in  1  PWM from the generator, same clock domain, may glitch combinationally
- dt_cfg  in  DT_W  new dead-time value
- dt_load  in  1  1-cycle strobe: dt_reg <= dt_cfg
- fault_in  in  1  synchronous fault request, level-sensitive
- fault_clr  in  1  1-cycle strobe to leave FAULT
- hs_out  out  1  high-side drive, registered
- ls_out  out  1  low-side drive, registered
- fault_latched  out  1  high while in FAULT
- drop_cnt  out  DROP_W  count of pulses swallowed by dead time, saturating

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-high on rst. All state resets on rst assertion; release is synchronous to clk.
- Reset values: state=OFF, hs_out=0, ls_out=0, fault_latched=0, drop_cnt=0, pwm_q=0, dt_reg=DEFAULT_DT, cnt=0.
- Input handling:
  - pwm_in is registered once (pwm_q). The FSM uses pwm_q only.
  - Outputs are flops decoded from next state.
- Effective dead time D = max(dt_reg,1). The both-low interval is never shorter than 1 cycle.
- FSM states: OFF, LS_ON, DT_TO_HS, HS_ON, DT_TO_LS, FAULT.
  - OFF (both low): next edge -> DT_TO_HS if pwm_q=1, else DT_TO_LS; cnt<=D-1.
  - LS_ON (ls=1): pwm_q=1 -> DT_TO_HS, cnt<=D-1.
  - DT_TO_HS (both low):
    - cnt!=0 -> cnt--.
    - cnt==0 and pwm_q=1 -> HS_ON.
    - cnt==0 and pwm_q=0 -> LS_ON; drop_cnt++ (pulse swallowed; HS never turned on, so no extra dead time).
  - HS_ON (hs=1): pwm_q=0 -> DT_TO_LS, cnt<=D-1.
  - DT_TO_LS: mirror of DT_TO_HS. Pulse-low shorter than D returns to HS_ON, drop_cnt++.
  - FAULT (both low, fault_latched=1): exit -> OFF only when fault_clr=1 and fault_in=0 in the same cycle. fault_clr while fault_in=1 is ignored.
- Fault priority: fault_in=1 in any state -> FAULT at next edge, both outputs 0 at that edge. This overrides every other transition.
- Timing, with pwm_q rising at edge E0 while in LS_ON:
  - ls_out falls at E1.
  - hs_out rises at E(1+D).
  - Falling transition is symmetric.
- dt_load:
  - dt_reg updates at the next edge.
  - The new value applies at the next DT entry. A dead time already in progress keeps its loaded cnt.
  - dt_load in the same cycle as a DT entry: the entry uses the old dt_reg.
- Exiting FAULT: always via OFF, so a full dead time elapses before either output turns on.
- drop_cnt saturates at all-ones. It is cleared only by rst.
- Invariant: hs_out & ls_out == 0 in every cycle, including reset release and fault entry/exit.

Decomposition:
- Package pwm_dt_pkg: state enum (6 states, 3-bit encoding) and the DEFAULT_DT/DT_W defaults.
- One sub-module, pwm_dt_timer: loadable down-counter with load/dec/zero flag. Reused for a future second half-bridge leg.
- FSM, output decode and drop counter stay in pwm_deadtime_gen.

Test Plan:
- Reset: assert rst mid-HS_ON -> hs_out, ls_out, fault_latched and drop_cnt go 0 immediately (async). After release with pwm_in=0: ls_out=1 after 1+D edges.
- DEFAULT_DT=2, pwm_in 0->1 held 10 cycles -> ls_out falls 1 edge after pwm_q rises, hs_out rises 3 edges after pwm_q rises. Then pwm_in 1->0 gives the mirrored result.
- dt_load with dt_cfg=5, then a 3-cycle high pulse -> hs_out never asserts, ls_out returns high, drop_cnt=1. Next 8-cycle pulse -> hs_out high for 3 cycles.
- dt_cfg=0 -> exactly 1 both-low cycle per transition. A checker asserting hs_out&ls_out==0 never fires over 1000 random pwm_in cycles.
- fault_in pulsed during HS_ON -> both low next edge, fault_latched=1. fault_clr while fault_in=1 -> stays in FAULT. Then fault_clr with fault_in=0 -> OFF, then the full D dead time before the output matching pwm_q turns on.
- 300 sub-dead-time pulses with DROP_W=8 -> drop_cnt saturates at 255 with no wrap.
